fake_data_bus: RTL and testbench
================================

FAKE_DATA_BUS -- requirements
Module: fake_data_bus

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, number of word-index bits; memory depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 read  input  1  read request for the current cycle.
REQ-005 write  input  1  write request for the current cycle.
REQ-006 address  input  32  byte address.
REQ-007 byteenable  input  4  write lane mask; bit i selects byte lane [8i+7:8i].
REQ-008 wdata  input  32  write data from the master.
REQ-009 rdata  output  32  read data word.
REQ-010 stall  output  1  high while the current access is not yet complete; master holds all requests stable while high.
REQ-011 data_w  output  32  merged word that a write in this cycle stores; used by bench monitors.

Function
REQ-012 Memory array inst_ram, 2**ADDR_WIDTH x 32 bits, is bench-writable by hierarchical reference; word index = address[ADDR_WIDTH+1:2].
REQ-013 address[1:0] and address bits above ADDR_WIDTH+1 are ignored; out-of-range addresses alias and never error.
REQ-014 data_w = per lane, wdata byte when byteenable bit set, else current inst_ram byte at the indexed word; combinational.
REQ-015 Write commit: on the completing cycle of a write access, inst_ram[index] <= data_w at the rising edge.
REQ-016 byteenable = 0 with write high: handshake completes, memory unchanged.
REQ-017 rdata = inst_ram[index], combinational; valid on the completing cycle of a read.
REQ-018 read and write both high: write is performed; rdata returns the pre-write word.
REQ-019 Neither read nor write high: stall = 0, no memory change.
REQ-020 Back-to-back accesses to the same word: the second access sees the first's data; no forwarding hazard.

Reset
REQ-021 While rst low: stall = 0, handshake state = IDLE, no write commits.
REQ-022 Reset asserted mid-access aborts it; the pending write is discarded.
REQ-023 inst_ram is not cleared by reset; the bench initialises it.
REQ-024 rdata and data_w follow REQ-014/REQ-017 during reset.

Configuration
REQ-025 Macro FAKE_DBUS_WAIT_EN: when defined, each access inserts one wait state; when undefined, every access completes in its request cycle.
REQ-026 Without macro: stall tied 0; read data and write commit in the same cycle as the request.
REQ-027 With macro: two-state machine IDLE/WAIT. IDLE + (read|write) -> stall = 1, go WAIT. WAIT -> stall = 0, access completes (read data valid, write commits), go IDLE.
REQ-028 With macro: a request dropped while in WAIT still returns to IDLE with no commit. A new request in the cycle after completion starts a fresh IDLE->WAIT sequence.

Verification
REQ-029 Reset low 3 cycles, then high -> stall = 0. Word 0x10 is unchanged from its bench-preloaded value.
REQ-030 Full-word write: address 0x0000_0040, wdata 0xDEADBEEF, byteenable 0xF -> data_w = 0xDEADBEEF. A following read of 0x40 returns 0xDEADBEEF.
REQ-031 Byte write: word 0x44 preloaded 0x11223344; write address 0x46, byteenable 0x4, wdata 0x00AA0000 -> data_w = 0x11AA3344 and memory = 0x11AA3344.
REQ-032 Aliasing: with ADDR_WIDTH = 14, write 0x0001_0008 with 0x12345678 -> read of 0x0008 returns 0x12345678.
REQ-033 FAKE_DBUS_WAIT_EN defined: a read request yields stall = 1 for one cycle, then stall = 0 with valid rdata. Reset pulsed during WAIT of a write -> memory unchanged.
REQ-034 Simultaneous read and write to 0x20, old value 0x0, new value 0x5 -> rdata = 0x0 this access; the next read returns 0x5.

Source files
------------

// File: rtl/fake_data_bus.sv
// fake_data_bus: word-addressed 32-bit memory model with a read/write/stall
// handshake, byte-lane write merging and address aliasing.
// Optional feature macro: FAKE_DBUS_WAIT_EN (one wait state per access).
// Without it every access completes in the cycle it is requested.
module fake_data_bus #(
   parameter int unsigned ADDR_WIDTH = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [3:0]  byteenable,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic [31:0] data_w
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   // Not reset; the bench preloads it by hierarchical reference.
   logic [31:0]           inst_ram [DEPTH];
   logic [ADDR_WIDTH-1:0] index;
   logic                  commit;
   logic                  unused_bits;

   // Byte offset and bits above the array range are dropped, so addresses alias.
   assign index = address[ADDR_WIDTH+1:2];

   // Read data is the current word; with read+write it is the pre-write value.
   assign rdata = inst_ram[index];

   // Merge enabled wdata lanes over the currently stored word.
   always_comb begin
      data_w = inst_ram[index];
      for (int unsigned i = 0; i < 4; i++) begin
         if (byteenable[i]) begin
            data_w[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

`ifdef FAKE_DBUS_WAIT_EN
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t state;

   // IDLE accepts a request and always moves to WAIT; WAIT completes and returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else if (state == IDLE && (read || write)) begin
         state <= WAIT;
      end else begin
         state <= IDLE;
      end
   end

   // Stall must rise in the request cycle itself, so it is decoded from state
   // and request rather than registered; reset forces state to IDLE, which
   // also cancels any commit of an in-flight write.
   assign stall       = rst && (state == IDLE) && (read || write);
   assign commit      = (state == WAIT) && write;
   assign unused_bits = ^{address[1:0], address[31:ADDR_WIDTH+2]};
`else
   assign stall       = 1'b0;
   assign commit      = rst && write;
   assign unused_bits = ^{read, address[1:0], address[31:ADDR_WIDTH+2]};
`endif

   // Commit the merged word on the completing cycle of a write.
   always_ff @(posedge clk) begin
      if (commit) begin
         inst_ram[index] <= data_w;
      end
   end

endmodule

// File: tb/tb_fake_data_bus.sv
// tb_fake_data_bus: table-driven scoreboard bench for fake_data_bus, with
// hand-written reset and wait-state sequences (FAKE_DBUS_WAIT_EN aware).
module tb_fake_data_bus;

   localparam int unsigned AW    = 14;
   localparam int unsigned DEPTH = 2 ** AW;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [3:0]  byteenable;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic [31:0] data_w;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   fake_data_bus #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .read       (read),
      .write      (write),
      .address    (address),
      .byteenable (byteenable),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .data_w     (data_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] er;
      logic [31:0] ed;
      string       nm;
   } sb_t;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] er;
      logic [31:0] ed;
      string       nm;
   } vec_t;

   sb_t  sbq[$];
   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Pop and compare on every completing cycle of a request.
   always @(negedge clk) begin
      if (mon_en && rst === 1'b1 && (read || write) && !stall) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: completion seen with empty scoreboard, expected none");
         end else begin
            sb_t e;
            e = sbq.pop_front();
            if (e.rd) chk({e.nm, "_rdata"}, rdata, e.er);
            if (e.wr) chk({e.nm, "_data_w"}, data_w, e.ed);
         end
      end
   end

   task automatic do_access(input vec_t v);
      sb_t e;
      int  n;
      read       = v.rd;
      write      = v.wr;
      address    = v.addr;
      byteenable = v.be;
      wdata      = v.wd;
      e.rd = v.rd;
      e.wr = v.wr;
      e.er = v.er;
      e.ed = v.ed;
      e.nm = v.nm;
      sbq.push_back(e);
      n = 0;
      @(negedge clk);
      while (stall && n < 8) begin
         n++;
         @(negedge clk);
      end
      if (stall) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: stall=%b after %0d cycles, expected 0", v.nm, stall, n);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t rd_vec(input logic [31:0] a, input logic [31:0] er, input string nm);
      vec_t v;
      v = '{1'b1, 1'b0, a, 4'h0, 32'h0, er, 32'h0, nm};
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1);
   end

   initial begin
      rst        = 1'b0;
      read       = 1'b1;
      write      = 1'b0;
      address    = 32'h10;
      byteenable = '0;
      wdata      = '0;

      for (int i = 0; i < int'(DEPTH); i++) begin
         dut.inst_ram[i] = 32'hC0DE_0000 | 32'(i);
      end
      dut.inst_ram[17] = 32'h1122_3344;
      dut.inst_ram[8]  = 32'h0000_0000;

      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, "wr_full"};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, "rd_full"};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0046, 4'h4, 32'h00AA_0000, 32'h0, 32'h11AA_3344, "wr_byte"};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'h11AA_3344, 32'h0, "rd_byte"};
      vecs[4]  = '{1'b0, 1'b1, 32'h0001_0008, 4'hF, 32'h1234_5678, 32'h0, 32'h1234_5678, "wr_alias"};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'h1234_5678, 32'h0, "rd_alias"};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h0000_0005, 32'h0, 32'h0000_0005, "rdwr"};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h0000_0005, 32'h0, "rd_after_rdwr"};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_0043, 4'h3, 32'h0000_1234, 32'h0, 32'hDEAD_1234, "wr_lo_offset"};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_1234, "wr_be0"};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0041, 4'h0, 32'h0, 32'hDEAD_1234, 32'h0, "rd_be0"};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_0080, 4'h9, 32'hAABB_CCDD, 32'h0, 32'hAADE_00DD, "wr_be9"};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0080, 4'h0, 32'h0, 32'hAADE_00DD, 32'h0, "rd_be9"};
      vecs[13] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hC0DE_0004, 32'h0, "rd_untouched"};

      // Reset held three cycles with a read request present.
      repeat (3) begin
         @(negedge clk);
         chk("reset_stall", 32'(stall), 32'h0);
      end
      @(posedge clk);
      #1;
      read = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      chk("post_reset_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1;

      mon_en = 1'b1;
      do_access(rd_vec(32'h10, 32'hC0DE_0004, "rd_preload"));

      foreach (vecs[i]) do_access(vecs[i]);
      read  = 1'b0;
      write = 1'b0;
      @(negedge clk);
      chk("idle_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1;

      // Write held high during reset must not commit.
      mon_en     = 1'b0;
      rst        = 1'b0;
      write      = 1'b1;
      address    = 32'h108;
      byteenable = 4'hF;
      wdata      = 32'h0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_write_stall", 32'(stall), 32'h0);
      end
      @(posedge clk);
      #1;
      write = 1'b0;
      rst   = 1'b1;
      mon_en = 1'b1;
      do_access(rd_vec(32'h108, 32'hC0DE_0042, "rd_after_rst_write"));
      read = 1'b0;

`ifdef FAKE_DBUS_WAIT_EN
      // Held read: stall alternates 1,0 with a fresh sequence each access.
      mon_en  = 1'b0;
      read    = 1'b1;
      address = 32'h10;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("wait_rd_stall_hi", 32'(stall), 32'h1);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("wait_rd_stall_lo", 32'(stall), 32'h0);
         chk("wait_rd_rdata", rdata, 32'hC0DE_0004);
         @(posedge clk);
         #1;
      end
      read = 1'b0;

      // Reset pulsed during WAIT of a write discards it.
      write      = 1'b1;
      address    = 32'h100;
      byteenable = 4'hF;
      wdata      = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("wait_wr_stall_hi", 32'(stall), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("wait_rst_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1;
      write = 1'b0;
      rst   = 1'b1;

      // Write dropped while in WAIT does not commit.
      write   = 1'b1;
      address = 32'h104;
      wdata   = 32'h0;
      @(negedge clk);
      chk("drop_stall_hi", 32'(stall), 32'h1);
      @(posedge clk);
      #1;
      write = 1'b0;
      @(negedge clk);
      chk("drop_stall_lo", 32'(stall), 32'h0);
      @(posedge clk);
      #1;

      mon_en = 1'b1;
      do_access(rd_vec(32'h100, 32'hC0DE_0040, "rd_after_wait_rst"));
      do_access(rd_vec(32'h104, 32'hC0DE_0041, "rd_after_drop"));
      read = 1'b0;
`else
      // Held read completes every cycle with no stall.
      mon_en  = 1'b0;
      read    = 1'b1;
      address = 32'h10;
      repeat (2) begin
         @(negedge clk);
         chk("nowait_rd_stall", 32'(stall), 32'h0);
         chk("nowait_rd_rdata", rdata, 32'hC0DE_0004);
         @(posedge clk);
         #1;
      end
      read   = 1'b0;
      mon_en = 1'b1;
`endif

      repeat (2) @(posedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
